mips_cpu_mem_sequencer: RTL and testbench
=========================================

Name: mips_cpu_mem_sequencer

Overview:
Multi-cycle data-memory access sequencer between the CPU core and a word-addressed, wait-state memory bus with byte enables. Accepts one load/store request at a time: lw/lh/lhu/lb/lbu/sw/sh/sb. Drives the bus transaction and holds the core stalled until the access completes. Returns the loaded data, already extracted from its byte lane and extended. Flags misaligned accesses without touching the bus.

Parameters:
ADDR_W, 32, byte-address width of the core and bus address.
DATA_W, 32, data width. Fixed at 32; any other value is unsupported.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  core presents a memory request; held until resp_valid
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 = byte, 01 = halfword, 10 = word; 11 = illegal, treated as word
req_signed  in  1  load sign-extends when 1 (lb/lh), zero-extends when 0 (lbu/lhu)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
stall  out  1  core must freeze its PC and pipeline while high
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data, valid with resp_valid
misaligned  out  1  one-cycle error pulse, coincident with resp_valid
bus_address  out  32  word-aligned address, {addr[31:2],2'b00}
bus_read  out  1  read strobe
bus_write  out  1  write strobe
bus_byteenable  out  4  lane enables; bit k enables bits 8k+7:8k
bus_writedata  out  32  lane-replicated store data
bus_waitrequest  in  1  high = bus has not accepted the transfer this cycle
bus_readdata  in  32  read data, valid in the cycle where bus_read=1 and waitrequest=0

Behaviour:
- Reset (synchronous, at the clock edge with reset=1):
  - state to IDLE.
  - stall, resp_valid, misaligned, bus_read, bus_write = 0.
  - bus_byteenable, bus_address, bus_writedata, resp_rdata = 0.
  - Reset mid-transaction abandons the access. Bus strobes are low in the cycle after the reset edge.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - stall = req_valid (combinational).
  - On req_valid, all req_* fields are registered.
  - Alignment check: halfword needs addr[0]=0; word needs addr[1:0]=00.
  - Misaligned request goes to RESP with an error latched. No bus strobe is ever raised.
  - Aligned request goes to ACCESS.
- ACCESS:
  - stall=1.
  - bus_read = !write, bus_write = write.
  - Address, byteenable and writedata come from registers and are held stable while waitrequest=1.
  - When waitrequest=0, bus_readdata is captured on a load and the FSM goes to RESP.
- RESP:
  - stall=0, resp_valid=1. misaligned=1 if the error is latched.
  - Strobes are low.
  - The next state is IDLE unconditionally.
  - The core advances this cycle, so req_valid seen in the next IDLE cycle is a new request.
- Minimum latency, waitrequest=0: request in cycle 0, strobe in cycle 1, resp_valid in cycle 2.
  - stall is high in cycles 0–1.
  - Each wait-state cycle adds one cycle.
- Byte enables:
  - byte: 0001 << addr[1:0].
  - half: 0011 when addr[1]=0, 1100 when addr[1]=1.
  - word: 1111.
- Lane mapping is little-endian: the byte at addr[1:0]=k sits on bits 8k+7:8k.
- Write data:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata unmodified.
- Read extraction, registered into resp_rdata:
  - The selected byte or halfword is right-justified.
  - It is then sign- or zero-extended per req_signed.
  - Word loads ignore req_signed.
- resp_rdata is 0 for stores and for misaligned accesses.
- resp_rdata holds its value until the next response.
- req_* changes after the request has been accepted are ignored until RESP.

Test Plan:
- lw at 0x00001004, waitrequest=0, readdata=0xDEADBEEF:
  - cycle 1: bus_read=1, bus_address=0x00001004, byteenable=1111.
  - cycle 2: resp_valid=1, resp_rdata=0xDEADBEEF, stall high in cycles 0–1 only.
- lb signed at 0x00002003, readdata=0x80123456 -> byteenable=1000, resp_rdata=0xFFFFFF80.
- lbu at the same address and data -> resp_rdata=0x00000080.
- lhu at 0x00002002, readdata=0xF00D1234 -> byteenable=1100, resp_rdata=0x0000F00D.
- sh at 0x00003002, wdata=0x0000ABCD, waitrequest high for 3 cycles:
  - bus_write=1, byteenable=1100 and writedata=0xABCDABCD held stable all 4 cycles.
  - resp_valid one cycle after waitrequest falls; total latency 5 cycles.
- lw at 0x00004002 (misaligned):
  - bus_read and bus_write never asserted.
  - misaligned=1 and resp_valid=1 in cycle 1, resp_rdata=0.
- sw in progress with waitrequest held high, reset=1 for one cycle:
  - next cycle: bus_write=0, stall=0, state IDLE.
  - a following lw completes normally.

Source files
------------

// File: rtl/mips_cpu_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_mem_sequencer
// Brief    : Multi-cycle data-memory access sequencer between the CPU core
//            and a word-addressed, wait-state memory bus with byte enables.
//            Handles lw/lh/lhu/lb/lbu/sw/sh/sb one request at a time, stalls
//            the core until completion, returns lane-extracted and extended
//            load data, and flags misaligned accesses without using the bus.
// Ports    : clk, reset                    - clock / sync active-high reset
//            req_valid/write/size/signed   - core request (held until resp)
//            req_addr, req_wdata           - byte address, right-justified data
//            stall                         - core freeze
//            resp_valid, resp_rdata        - completion pulse and load data
//            misaligned                    - error pulse, with resp_valid
//            bus_address/read/write        - word address and strobes
//            bus_byteenable, bus_writedata - lane enables, replicated data
//            bus_waitrequest, bus_readdata - bus handshake and read data
// Revision : 1.0 - initial release
// ============================================================================
module mips_cpu_mem_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32   // only 32 is supported
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              misaligned,
  output logic [ADDR_W-1:0] bus_address,
  output logic              bus_read,
  output logic              bus_write,
  output logic [3:0]        bus_byteenable,
  output logic [DATA_W-1:0] bus_writedata,
  input  logic              bus_waitrequest,
  input  logic [DATA_W-1:0] bus_readdata
);

  localparam logic [1:0] c_size_byte = 2'b00;
  localparam logic [1:0] c_size_half = 2'b01;
  localparam logic [1:0] c_size_word = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Request fields captured at acceptance; the core may change req_* afterwards.
  logic       r_write;
  logic [1:0] r_size;
  logic       r_signed;
  logic [1:0] r_lane;
  logic       r_err;

  logic [1:0]        w_size_eff;
  logic              w_misaligned;
  logic [3:0]        w_byteenable;
  logic [DATA_W-1:0] w_writedata;
  logic [7:0]        w_rd_byte;
  logic [15:0]       w_rd_half;
  logic [DATA_W-1:0] w_load_data;

  // Size 11 is illegal and handled exactly like a word access.
  assign w_size_eff = (req_size == 2'b11) ? c_size_word : req_size;

  assign w_misaligned = ((w_size_eff == c_size_half) && req_addr[0]) ||
                        ((w_size_eff == c_size_word) && (req_addr[1:0] != 2'b00));

  always_comb begin
    w_byteenable = 4'b1111;
    w_writedata  = req_wdata;
    case (w_size_eff)
      c_size_byte: begin
        w_byteenable = 4'b0001 << req_addr[1:0];
        w_writedata  = {4{req_wdata[7:0]}};
      end
      c_size_half: begin
        w_byteenable = req_addr[1] ? 4'b1100 : 4'b0011;
        w_writedata  = {2{req_wdata[15:0]}};
      end
      default: begin
        w_byteenable = 4'b1111;
        w_writedata  = req_wdata;
      end
    endcase
  end

  // Little-endian lane extraction from the bus word using the latched offset.
  always_comb begin
    w_rd_byte = bus_readdata[7:0];
    case (r_lane)
      2'd0:    w_rd_byte = bus_readdata[7:0];
      2'd1:    w_rd_byte = bus_readdata[15:8];
      2'd2:    w_rd_byte = bus_readdata[23:16];
      default: w_rd_byte = bus_readdata[31:24];
    endcase
  end

  assign w_rd_half = r_lane[1] ? bus_readdata[31:16] : bus_readdata[15:0];

  always_comb begin
    w_load_data = bus_readdata;
    case (r_size)
      c_size_byte: w_load_data = {{24{r_signed & w_rd_byte[7]}}, w_rd_byte};
      c_size_half: w_load_data = {{16{r_signed & w_rd_half[15]}}, w_rd_half};
      default:     w_load_data = bus_readdata;
    endcase
  end

  // Next state and handshake outputs.
  always_comb begin
    w_next_state = r_state;
    stall        = 1'b0;
    resp_valid   = 1'b0;
    misaligned   = 1'b0;
    bus_read     = 1'b0;
    bus_write    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        stall = req_valid;
        if (req_valid) begin
          w_next_state = w_misaligned ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        stall     = 1'b1;
        bus_read  = ~r_write;
        bus_write = r_write;
        if (!bus_waitrequest) begin
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        // The core advances in this cycle, so the next IDLE sees a new request.
        resp_valid   = 1'b1;
        misaligned   = r_err;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_write        <= 1'b0;
      r_size         <= 2'b00;
      r_signed       <= 1'b0;
      r_lane         <= 2'b00;
      r_err          <= 1'b0;
      bus_address    <= '0;
      bus_byteenable <= 4'b0000;
      bus_writedata  <= '0;
      resp_rdata     <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_write  <= req_write;
            r_size   <= w_size_eff;
            r_signed <= req_signed;
            r_lane   <= req_addr[1:0];
            r_err    <= w_misaligned;
            if (w_misaligned) begin
              resp_rdata <= '0;
            end else begin
              // Bus-facing registers only move for accesses that use the bus.
              bus_address    <= {req_addr[ADDR_W-1:2], 2'b00};
              bus_byteenable <= w_byteenable;
              bus_writedata  <= w_writedata;
            end
          end
        end
        ST_ACCESS: begin
          if (!bus_waitrequest) begin
            resp_rdata <= r_write ? '0 : w_load_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_cpu_mem_sequencer
// Brief    : Self-checking bench for mips_cpu_mem_sequencer. Directed test
//            plan cases followed by randomized requests, each checked cycle
//            by cycle against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_mem_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        misaligned;
  logic [31:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [3:0]  bus_byteenable;
  logic [31:0] bus_writedata;
  logic        bus_waitrequest;
  logic [31:0] bus_readdata;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_rdata;
  logic [31:0] got;

  always #5 clk = ~clk;

  mips_cpu_mem_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .misaligned(misaligned), .bus_address(bus_address), .bus_read(bus_read),
    .bus_write(bus_write), .bus_byteenable(bus_byteenable),
    .bus_writedata(bus_writedata), .bus_waitrequest(bus_waitrequest),
    .bus_readdata(bus_readdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_misaligned(input logic [1:0] sz, input logic [31:0] a);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
    int n = nbytes(sz);
    int off = a % 4;
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [31:0] wd);
    int n = nbytes(sz);
    if (n == 1) return {24'd0, wd[7:0]} * 32'h01010101;
    if (n == 2) return {16'd0, wd[15:0]} * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] model_rd(input logic [1:0] sz, input bit sg,
                                           input logic [31:0] a, input logic [31:0] rd);
    int n = nbytes(sz);
    int off = a % 4;
    logic [31:0] v;
    v = rd >> (8 * off);
    if (n < 4) begin
      v = v & ((32'd1 << (8 * n)) - 32'd1);
      if (sg && (((v >> (8 * n - 1)) & 32'd1) == 32'd1)) v = v - (32'd1 << (8 * n));
    end
    return v;
  endfunction

  // One complete request, checked every cycle. nw = wait-state cycles.
  task automatic do_txn(input bit w, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int nw, input logic [31:0] rd,
                        output logic [31:0] got_rdata);
    logic [1:0]  es;
    bit          mis;
    logic [31:0] exp_rd;
    es     = (sz == 2'd3) ? 2'd2 : sz;
    mis    = is_misaligned(es, a);
    exp_rd = (mis || w) ? 32'd0 : model_rd(es, sg, a, rd);

    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    bus_waitrequest = 1'b1; bus_readdata = $urandom;
    #1;
    chk("req_stall", {31'd0, stall}, 32'd1);
    chk("req_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("req_strobes", {30'd0, bus_read, bus_write}, 32'd0);
    chk("rdata_hold", resp_rdata, last_rdata);

    if (!mis) begin
      for (int c = 0; c <= nw; c++) begin
        @(negedge clk);
        // Post-acceptance request changes must be ignored.
        req_write = $urandom; req_size = $urandom; req_signed = $urandom;
        req_addr = $urandom; req_wdata = $urandom;
        bus_waitrequest = (c < nw);
        bus_readdata = (c < nw) ? $urandom : rd;
        #1;
        chk("acc_stall", {31'd0, stall}, 32'd1);
        chk("acc_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("acc_read", {31'd0, bus_read}, {31'd0, !w});
        chk("acc_write", {31'd0, bus_write}, {31'd0, w});
        chk("acc_address", bus_address, {a[31:2], 2'b00});
        chk("acc_byteenable", {28'd0, bus_byteenable}, {28'd0, model_be(es, a)});
        if (w) chk("acc_writedata", bus_writedata, model_wd(es, wd));
      end
    end

    @(negedge clk);
    req_addr = $urandom; req_wdata = $urandom;
    bus_waitrequest = $urandom; bus_readdata = $urandom;
    #1;
    chk("resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("resp_misaligned", {31'd0, misaligned}, {31'd0, mis});
    chk("resp_stall", {31'd0, stall}, 32'd0);
    chk("resp_strobes", {30'd0, bus_read, bus_write}, 32'd0);
    chk("resp_rdata", resp_rdata, exp_rd);
    got_rdata  = resp_rdata;
    last_rdata = exp_rd;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    bus_waitrequest = 1'b0; bus_readdata = 32'd0;
    last_rdata = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
    chk("rst_strobes", {30'd0, bus_read, bus_write}, 32'd0);
    chk("rst_byteenable", {28'd0, bus_byteenable}, 32'd0);
    chk("rst_address", bus_address, 32'd0);
    chk("rst_writedata", bus_writedata, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);

    // Directed cases
    do_txn(1'b0, 2'd2, 1'b0, 32'h00001004, 32'd0, 0, 32'hDEADBEEF, got);
    chk("lw_value", got, 32'hDEADBEEF);
    do_txn(1'b0, 2'd0, 1'b1, 32'h00002003, 32'd0, 0, 32'h80123456, got);
    chk("lb_value", got, 32'hFFFFFF80);
    do_txn(1'b0, 2'd0, 1'b0, 32'h00002003, 32'd0, 0, 32'h80123456, got);
    chk("lbu_value", got, 32'h00000080);
    do_txn(1'b0, 2'd1, 1'b0, 32'h00002002, 32'd0, 0, 32'hF00D1234, got);
    chk("lhu_value", got, 32'h0000F00D);
    do_txn(1'b1, 2'd1, 1'b0, 32'h00003002, 32'h0000ABCD, 3, 32'd0, got);
    chk("sh_value", got, 32'd0);
    do_txn(1'b0, 2'd2, 1'b0, 32'h00004002, 32'd0, 0, 32'h12345678, got);
    chk("mis_value", got, 32'd0);
    do_txn(1'b0, 2'd3, 1'b1, 32'h00005008, 32'd0, 1, 32'h87654321, got);
    chk("size3_value", got, 32'h87654321);

    // Reset in the middle of a store held by waitrequest
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h00006000; req_wdata = 32'h11223344; bus_waitrequest = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_write", {31'd0, bus_write}, 32'd1);
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_write", {31'd0, bus_write}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    chk("mid_rst_resp", {31'd0, resp_valid}, 32'd0);
    last_rdata = 32'd0;
    do_txn(1'b0, 2'd2, 1'b0, 32'h00007000, 32'd0, 0, 32'hCAFEF00D, got);
    chk("post_rst_lw", got, 32'hCAFEF00D);

    // Randomized requests
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = ($urandom_range(0, 1) == 0) ? 2'b00 : a[1:0] & 2'b10;
      do_txn(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom,
             int'($urandom_range(0, 3)), $urandom, got);
    end

    @(negedge clk);
    req_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
